serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller that computes A − B over WIDTH clock cycles, LSB first.
- Each cycle it feeds one bit pair plus the running borrow through two cascaded half-subtractor cells, forming a full-subtractor stage.
- It owns the operand shift registers, the borrow flip-flop, the bit counter and the start/done handshake.
- Used where area matters more than latency; replaces a WIDTH-wide ripple subtractor.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result A − B modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff A < B (unsigned).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. rst_n=0 sampled at a rising edge forces state=IDLE, counter=0, borrow=0, shift regs=0, diff=0, borrow_out=0, done=0, busy=0, ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at edge E0, latch a and b into shift regs, set counter=0 and borrow=0, go to RUN. Otherwise hold.
- RUN: at each edge E1..E_WIDTH, process bit i = counter using LSB of the shift regs.
  - Stage 1: d1 = a_i ^ b_i, br1 = ~a_i & b_i.
  - Stage 2: d = d1 ^ borrow, br2 = ~d1 & borrow.
  - borrow <= br1 | br2.
  - d is shifted into the MSB of the result shift reg; the operand regs shift right; counter increments.
  - At edge E_WIDTH (counter reaches WIDTH−1 before the edge): load diff from the completed result shift reg, set borrow_out = final borrow, go to DONE.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE and clears done.
- Latency: start accepted at E0; busy high for WIDTH cycles; done high in the cycle after E_WIDTH. A new start is accepted at the edge after E_WIDTH+1. Total start-to-start: WIDTH+2 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.
- ready and busy are decoded from the state register.
- diff and borrow_out change only on the completion edge and hold until the next completion or reset. They are not cleared at start.
- start while in RUN or DONE: ignored, with no effect on the operands or the result.
- a and b changing after acceptance: no effect on the current operation.
- rst_n low mid-RUN: operation aborted and all outputs cleared per reset. The next cycle is IDLE with ready=1.
- rst_n low in the same cycle as start: reset wins; start is not accepted.
- WIDTH=1: RUN lasts exactly one cycle, and the counter never wraps.
- Counter range is 0..WIDTH−1. It is never compared against values ≥ WIDTH.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, start pulse at E0 → busy high for 8 cycles, done high in cycle 9 only, diff=0x1E, borrow_out=0.
2. a=0x00, b=0x01 → diff=0xFF, borrow_out=1. Also a=0x80, b=0x80 → diff=0x00, borrow_out=0.
3. Start at E0 with a=0x10, b=0x01; at E3 raise start with a=0xFF, b=0x00 → ignored; final diff=0x0F, and ready stays low until after done.
4. Start with a=0xF0, b=0x0F; pull rst_n low at E4 → next cycle state IDLE, diff=0, borrow_out=0, done never asserted. A fresh start then gives a correct result.
5. Back-to-back: hold start=1 continuously with fixed operands → accepted every WIDTH+2 cycles, done pulses periodic, and results identical.
6. WIDTH=1 build, all four (a,b) combinations → diff/borrow_out = (0,0), (1,1), (1,0), (0,0) for (0,0), (0,1), (1,0), (1,1); done at the cycle after E1. Also a randomized 1000-operation run at WIDTH=8 checked against a reference model.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial LSB-first subtractor with start/done handshake

// Single half-subtractor cell: difference and borrow of x - y.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic br
);
  assign d  = x ^ y;
  assign br = ~x & y;
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value of the final bit; never compared against anything >= WIDTH.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;

  logic d1;
  logic br1;
  logic d;
  logic br2;
  logic borrow_next;

  // Two cascaded half-subtractors form the full-subtractor stage for the current bit.
  half_sub u_hs1 (.x(a_sh[0]), .y(b_sh[0]), .d(d1), .br(br1));
  half_sub u_hs2 (.x(d1),      .y(borrow),  .d(d),  .br(br2));

  assign borrow_next = br1 | br2;

  // New difference bit enters at the MSB so the LSB-first stream lands in order.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d;
    end else begin : g_res_wn
      assign res_next = {d, res_sh[WIDTH-1:1]};
    end
  endgenerate

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

  // Control FSM plus datapath registers; results update only on the completion edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      borrow     <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            cnt    <= '0;
            borrow <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          borrow <= borrow_next;
          res_sh <= res_next;
          if (cnt == LAST) begin
            diff       <= res_next;
            borrow_out <= borrow_next;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
